pipeline_issue_ctrl: RTL and testbench

Instruction issue controller placed in front of the 3-stage ALU pipeline; it owns the pipeline's 32-bit instruction input. It buffers incoming instructions in a small FIFO, detects read-after-write hazards against instructions still in flight (the pipeline has no forwarding), and inserts NOP bubbles until each operand's producer has written the register file. It also counts issued instructions and hazard stall cycles for performance checks.

---
 rtl/pipeline_issue_ctrl_pkg.sv | 49 ++++
 rtl/pipeline_issue_ctrl_fifo.sv | 55 +++++
 rtl/pipeline_issue_ctrl.sv | 81 ++++++++
 tb/tb_pipeline_issue_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_issue_ctrl_pkg.sv
// Shared definitions for the issue controller: instruction field layout,
// the NOP encoding, and helpers that extract fields and test operand overlap.
// Pure definitions; no timing or flow control.
package pipeline_issue_ctrl_pkg;

  localparam int INSTR_W      = 32;
  localparam int REG_W        = 5;
  localparam int DATA_SRC_BIT = 31;
  localparam int WE_BIT       = 27;
  localparam int WSEL_LSB     = 22;
  localparam int RSEL1_LSB    = 17;
  localparam int RSEL2_LSB    = 11;

  typedef logic [INSTR_W-1:0] instr_t;
  typedef logic [REG_W-1:0]   reg_sel_t;

  localparam instr_t NOP_INSTR = '0;

  function automatic logic f_data_src(input instr_t i);
    return i[DATA_SRC_BIT];
  endfunction

  function automatic logic f_we(input instr_t i);
    return i[WE_BIT];
  endfunction

  function automatic reg_sel_t f_wsel(input instr_t i);
    return i[WSEL_LSB +: REG_W];
  endfunction

  function automatic reg_sel_t f_rsel1(input instr_t i);
    return i[RSEL1_LSB +: REG_W];
  endfunction

  function automatic reg_sel_t f_rsel2(input instr_t i);
    return i[RSEL2_LSB +: REG_W];
  endfunction

  // True when consumer reads a register that producer writes. read_sel2
  // shares bits with the immediate, so it only counts for register-source ops.
  function automatic logic raw_dep(input instr_t producer, input instr_t consumer);
    logic hit1;
    logic hit2;
    hit1 = (f_wsel(producer) == f_rsel1(consumer));
    hit2 = !f_data_src(consumer) && (f_wsel(producer) == f_rsel2(consumer));
    return f_we(producer) && (hit1 || hit2);
  endfunction

endpackage

// File: rtl/pipeline_issue_ctrl_fifo.sv
// Purpose: DEPTH x W instruction queue with count-based full/empty.
// Latency: push visible at dout one cycle later; dout is the head, read combinationally.
// Backpressure: full blocks pushes; a same-cycle pop does not free a slot for the push.
// Ports: push/din/full on the write side, pop/dout/empty on the read side.
module issue_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  output logic         full,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pipeline_issue_ctrl.sv
// Purpose: queue instructions and issue them to a non-forwarding 3-stage ALU, bubbling on RAW hazards.
// Latency: instruction pushed into an empty queue at edge N is on issue_instr after edge N+1.
// Backpressure: in_ready = queue not full; a hazard holds the head and inserts a NOP.
// Ports: in_valid/in_ready/in_instr upstream; issue_instr/issue_valid/stall to the pipeline;
//        fifo_empty status; issue_cnt/stall_cnt wrapping performance counters.
module pipeline_issue_ctrl
  import pipeline_issue_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic [31:0]      issue_instr,
  output logic             issue_valid,
  output logic             stall,
  output logic             fifo_empty,
  output logic [CNT_W-1:0] issue_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  instr_t head;
  instr_t hist_instr;
  logic   full;
  logic   hazard;
  logic   pop;

  issue_fifo #(
    .DEPTH (DEPTH),
    .W     (INSTR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .din   (in_instr),
    .full  (full),
    .pop   (pop),
    .dout  (head),
    .empty (fifo_empty)
  );

  assign in_ready = !full;

  // The two most recent slots are still ahead of register-file write-back,
  // so the head must wait until neither of them produces one of its operands.
  assign hazard = !fifo_empty &&
                  (raw_dep(issue_instr, head) || raw_dep(hist_instr, head));
  assign pop    = !fifo_empty && !hazard;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_instr <= NOP_INSTR;
      hist_instr  <= NOP_INSTR;
      issue_valid <= 1'b0;
      stall       <= 1'b0;
      issue_cnt   <= '0;
      stall_cnt   <= '0;
    end else begin
      hist_instr <= issue_instr;
      if (fifo_empty) begin
        issue_instr <= NOP_INSTR;
        issue_valid <= 1'b0;
        stall       <= 1'b0;
      end else if (hazard) begin
        issue_instr <= NOP_INSTR;
        issue_valid <= 1'b0;
        stall       <= 1'b1;
        stall_cnt   <= stall_cnt + 1'b1;
      end else begin
        issue_instr <= head;
        issue_valid <= 1'b1;
        stall       <= 1'b0;
        issue_cnt   <= issue_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_issue_ctrl.sv
// Directed bench for pipeline_issue_ctrl: reset, independent stream, RAW spacing,
// immediate masking, queue full/backpressure, and asynchronous reset mid-stall.
// Inputs change and outputs are sampled on the falling edge.
module tb_pipeline_issue_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] issue_instr;
  logic        issue_valid;
  logic        stall;
  logic        fifo_empty;
  logic [15:0] issue_cnt;
  logic [15:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  pipeline_issue_ctrl #(.DEPTH(4), .CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .issue_instr (issue_instr),
    .issue_valid (issue_valid),
    .stall       (stall),
    .fifo_empty  (fifo_empty),
    .issue_cnt   (issue_cnt),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Build an instruction: src=data_src, we=write_enable, rd=write_select.
  function automatic logic [31:0] mk(input logic src, input logic we, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2);
    logic [31:0] v;
    v = '0;
    v[31]    = src;
    v[30:28] = 3'd2;
    v[27]    = we;
    v[26:22] = rd;
    v[21:17] = rs1;
    v[15:11] = rs2;
    return v;
  endfunction

  logic [31:0] a, b, c, d, i0, i1, j0, j1, j2, k0, k1, k2;
  logic [31:0] l0, l1, l2, l3, l4, l5, l6, m0, m1, m2, m3, n0;

  initial begin
    a  = mk(0, 1, 1, 10, 11);  b  = mk(0, 1, 2, 10, 11);
    c  = mk(0, 1, 3, 10, 11);  d  = mk(0, 1, 4, 10, 11);
    i0 = mk(0, 1, 5, 20, 21);  i1 = mk(0, 1, 6, 5, 21);
    j0 = mk(0, 1, 7, 20, 21);  j1 = mk(0, 1, 8, 22, 23);  j2 = mk(0, 1, 9, 24, 7);
    k0 = mk(0, 1, 7, 20, 21);  k1 = mk(0, 1, 8, 22, 23);  k2 = mk(1, 1, 9, 24, 7);
    l0 = mk(0, 1, 12, 20, 21); l1 = mk(0, 1, 13, 12, 21); l2 = mk(0, 1, 15, 13, 21);
    l3 = mk(0, 1, 14, 20, 21); l4 = mk(0, 1, 16, 20, 21); l5 = mk(0, 1, 17, 20, 21);
    l6 = mk(0, 1, 18, 20, 21);
    m0 = mk(0, 1, 12, 20, 21); m1 = mk(0, 1, 13, 12, 21);
    m2 = mk(0, 1, 14, 20, 21); m3 = mk(0, 1, 15, 20, 21);
    n0 = mk(0, 1, 3, 20, 21);

    // Reset held with in_valid asserted: nothing may be queued.
    rst = 1'b0; in_valid = 1'b1; in_instr = a;
    repeat (2) @(negedge clk);
    chk("rst_issue_instr", issue_instr, 32'h0);
    chk("rst_issue_valid", {31'd0, issue_valid}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_fifo_empty", {31'd0, fifo_empty}, 32'd1);
    chk("rst_issue_cnt", {16'd0, issue_cnt}, 32'd0);
    chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    in_valid = 1'b0; rst = 1'b1;
    step();
    chk("post_rst_valid", {31'd0, issue_valid}, 32'd0);
    chk("post_rst_empty", {31'd0, fifo_empty}, 32'd1);

    // Independent stream: one issue per cycle, no stalls.
    in_valid = 1'b1; in_instr = a; step();
    chk("ind_latency_valid", {31'd0, issue_valid}, 32'd0);
    chk("ind_queued", {31'd0, fifo_empty}, 32'd0);
    in_instr = b; step();
    chk("ind_a", issue_instr, a);
    chk("ind_a_valid", {31'd0, issue_valid}, 32'd1);
    in_instr = c; step();
    chk("ind_b", issue_instr, b);
    chk("ind_b_stall", {31'd0, stall}, 32'd0);
    in_instr = d; step();
    chk("ind_c", issue_instr, c);
    in_valid = 1'b0; step();
    chk("ind_d", issue_instr, d);
    chk("ind_d_valid", {31'd0, issue_valid}, 32'd1);
    chk("ind_issue_cnt", {16'd0, issue_cnt}, 32'd4);
    chk("ind_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    step();
    chk("ind_drain_valid", {31'd0, issue_valid}, 32'd0);
    chk("ind_drain_empty", {31'd0, fifo_empty}, 32'd1);

    // Back-to-back RAW through read_sel1: two bubbles.
    in_valid = 1'b1; in_instr = i0; step();
    in_instr = i1; step();
    chk("raw_i0", issue_instr, i0);
    in_valid = 1'b0; step();
    chk("raw_bub1_stall", {31'd0, stall}, 32'd1);
    chk("raw_bub1_instr", issue_instr, 32'h0);
    chk("raw_bub1_valid", {31'd0, issue_valid}, 32'd0);
    step();
    chk("raw_bub2_stall", {31'd0, stall}, 32'd1);
    step();
    chk("raw_i1", issue_instr, i1);
    chk("raw_i1_stall", {31'd0, stall}, 32'd0);
    chk("raw_stall_cnt", {16'd0, stall_cnt}, 32'd2);
    chk("raw_issue_cnt", {16'd0, issue_cnt}, 32'd6);
    step();

    // Distance-2 dependency via read_sel2: one bubble.
    in_valid = 1'b1; in_instr = j0; step();
    in_instr = j1; step();
    chk("d2_j0", issue_instr, j0);
    in_instr = j2; step();
    chk("d2_j1", issue_instr, j1);
    in_valid = 1'b0; step();
    chk("d2_bubble", {31'd0, stall}, 32'd1);
    step();
    chk("d2_j2", issue_instr, j2);
    chk("d2_stall_cnt", {16'd0, stall_cnt}, 32'd3);
    step();

    // Same pattern with an immediate source: read_sel2 bits ignored, no bubble.
    in_valid = 1'b1; in_instr = k0; step();
    in_instr = k1; step();
    chk("imm_k0", issue_instr, k0);
    in_instr = k2; step();
    chk("imm_k1", issue_instr, k1);
    in_valid = 1'b0; step();
    chk("imm_k2", issue_instr, k2);
    chk("imm_k2_stall", {31'd0, stall}, 32'd0);
    chk("imm_stall_cnt", {16'd0, stall_cnt}, 32'd3);
    chk("imm_issue_cnt", {16'd0, issue_cnt}, 32'd12);
    step();

    // Fill the queue behind a dependency chain, then drain in order.
    in_valid = 1'b1; in_instr = l0; step();
    in_instr = l1; step();
    chk("full_l0", issue_instr, l0);
    in_instr = l2; step();
    chk("full_stall_a", {31'd0, stall}, 32'd1);
    in_instr = l3; step();
    chk("full_stall_b", {31'd0, stall}, 32'd1);
    chk("full_ready_3", {31'd0, in_ready}, 32'd1);
    in_instr = l4; step();
    chk("full_l1", issue_instr, l1);
    in_instr = l5; step();
    chk("full_stall_c", {31'd0, stall}, 32'd1);
    chk("full_ready_0", {31'd0, in_ready}, 32'd0);
    in_instr = l6; step();
    chk("full_ready_held", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0; step();
    chk("full_l2", issue_instr, l2);
    chk("full_ready_back", {31'd0, in_ready}, 32'd1);
    step();
    chk("full_l3", issue_instr, l3);
    step();
    chk("full_l4", issue_instr, l4);
    step();
    chk("full_l5", issue_instr, l5);
    step();
    chk("full_no_l6_valid", {31'd0, issue_valid}, 32'd0);
    chk("full_no_l6_empty", {31'd0, fifo_empty}, 32'd1);
    chk("full_stall_cnt", {16'd0, stall_cnt}, 32'd7);
    chk("full_issue_cnt", {16'd0, issue_cnt}, 32'd18);

    // Asynchronous reset while stalled with three queued entries.
    in_valid = 1'b1; in_instr = m0; step();
    in_instr = m1; step();
    chk("ar_m0", issue_instr, m0);
    in_instr = m2; step();
    in_instr = m3; step();
    chk("ar_stalled", {31'd0, stall}, 32'd1);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("ar_issue_instr", issue_instr, 32'h0);
    chk("ar_stall", {31'd0, stall}, 32'd0);
    chk("ar_valid", {31'd0, issue_valid}, 32'd0);
    chk("ar_empty", {31'd0, fifo_empty}, 32'd1);
    chk("ar_ready", {31'd0, in_ready}, 32'd1);
    chk("ar_issue_cnt", {16'd0, issue_cnt}, 32'd0);
    chk("ar_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("ar_rel_valid1", {31'd0, issue_valid}, 32'd0);
    step();
    chk("ar_rel_valid2", {31'd0, issue_valid}, 32'd0);
    chk("ar_rel_stall", {31'd0, stall}, 32'd0);
    in_valid = 1'b1; in_instr = n0; step();
    in_valid = 1'b0; step();
    chk("ar_new_n0", issue_instr, n0);
    chk("ar_new_cnt", {16'd0, issue_cnt}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
